// File: rtl/dds_sweep_sequencer.sv
// dds_sweep_sequencer: plays a host-loaded table of 16-bit DDS words into
// dds_control with a per-word dwell, optional looping and a priority host path.
// Ports:
//   clk, rstn                     - clock, async active-low reset
//   tbl_wr_en/addr/data           - synchronous table write port
//   cfg_last/dwell/loop           - sweep config, latched on accepted start
//   start, abort                  - sweep control pulses
//   host_req/host_word/host_ack   - one-shot host write path
//   dds_control_data/update       - word and strobe toward dds_control
//   spi_ready                     - dds_control idle flag (low while shifting)
//   busy, done, step_idx, skip_cnt - status
module dds_sweep_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int DWELL_W     = 24,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tbl_wr_en,
    input  logic [AW-1:0]      tbl_wr_addr,
    input  logic [15:0]        tbl_wr_data,
    input  logic [AW-1:0]      cfg_last,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               abort,
    input  logic               host_req,
    input  logic [15:0]        host_word,
    output logic               host_ack,
    output logic [15:0]        dds_control_data,
    output logic               dds_control_update,
    input  logic               spi_ready,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      step_idx,
    output logic [7:0]         skip_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DWELL
    } state_t;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t             state;
    logic [15:0]        tbl [DEPTH];
    logic [AW-1:0]      lat_last;
    logic [DWELL_W-1:0] lat_dwell;
    logic               lat_loop;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [TW-1:0]      to_cnt;
    logic               src_host;
    logic               sweep_on;
    logic               abort_pend;
    logic               ack_to;
    logic               xfer_done;
    logic               to_idle;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (tbl_wr_en) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // A word completes either on the spi_ready rise or when dds_control
    // never started shifting (it drops a word equal to its previous one).
    assign ack_to    = (state == S_WAIT_ACK) && spi_ready && (to_cnt == TO_LAST);
    assign xfer_done = ack_to || ((state == S_WAIT_DONE) && spi_ready);
    // After a completed host word with no sweep running there is no dwell.
    assign to_idle   = abort || abort_pend || (src_host && !sweep_on);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= S_IDLE;
            lat_last           <= '0;
            lat_dwell          <= '0;
            lat_loop           <= 1'b0;
            dwell_cnt          <= '0;
            to_cnt             <= '0;
            src_host           <= 1'b0;
            sweep_on           <= 1'b0;
            abort_pend         <= 1'b0;
            host_ack           <= 1'b0;
            dds_control_data   <= '0;
            dds_control_update <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            step_idx           <= '0;
            skip_cnt           <= '0;
        end else begin
            dds_control_update <= 1'b0;
            host_ack           <= 1'b0;
            done               <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    if (!abort) begin
                        if (host_req) begin
                            dds_control_data   <= host_word;
                            dds_control_update <= 1'b1;
                            src_host           <= 1'b1;
                            sweep_on           <= 1'b0;
                            busy               <= 1'b1;
                            state              <= S_ISSUE;
                        end else if (start) begin
                            lat_last  <= cfg_last;
                            lat_dwell <= cfg_dwell;
                            lat_loop  <= cfg_loop;
                            step_idx  <= '0;
                            sweep_on  <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        sweep_on <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        dds_control_data   <= tbl[step_idx];
                        dds_control_update <= 1'b1;
                        src_host           <= 1'b0;
                        state              <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) abort_pend <= 1'b1;
                    to_cnt <= '0;
                    state  <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (abort) abort_pend <= 1'b1;
                    if (!spi_ready) begin
                        state <= S_WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        if (skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (abort) abort_pend <= 1'b1;
                end
                S_DWELL: begin
                    if (abort) begin
                        sweep_on <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (host_req) begin
                        dds_control_data   <= host_word;
                        dds_control_update <= 1'b1;
                        src_host           <= 1'b1;
                        state              <= S_ISSUE;
                    end else if (dwell_cnt <= DWELL_W'(1)) begin
                        if (step_idx < lat_last) begin
                            step_idx <= step_idx + AW'(1);
                            state    <= S_LOAD;
                        end else if (lat_loop) begin
                            step_idx <= '0;
                            state    <= S_LOAD;
                        end else begin
                            done     <= 1'b1;
                            sweep_on <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            if (xfer_done) begin
                host_ack <= src_host;
                if (to_idle) begin
                    sweep_on   <= 1'b0;
                    abort_pend <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end else begin
                    dwell_cnt <= lat_dwell;
                    state     <= S_DWELL;
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Testbench for dds_sweep_sequencer: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model and literal values.
module tb_dds_sweep_sequencer;
    localparam int AW  = 4;
    localparam int DWW = 24;
    localparam int TO  = 8;

    logic            clk         = 1'b0;
    logic            rstn        = 1'b0;
    logic            tbl_wr_en   = 1'b0;
    logic [AW-1:0]   tbl_wr_addr = '0;
    logic [15:0]     tbl_wr_data = '0;
    logic [AW-1:0]   cfg_last    = '0;
    logic [DWW-1:0]  cfg_dwell   = '0;
    logic            cfg_loop    = 1'b0;
    logic            start       = 1'b0;
    logic            abort       = 1'b0;
    logic            host_req    = 1'b0;
    logic [15:0]     host_word   = '0;
    logic            spi_ready   = 1'b1;
    logic            host_ack;
    logic [15:0]     dds_control_data;
    logic            dds_control_update;
    logic            busy;
    logic            done;
    logic [AW-1:0]   step_idx;
    logic [7:0]      skip_cnt;

    always #5 clk = ~clk;

    dds_sweep_sequencer #(
        .DEPTH(16), .AW(AW), .DWELL_W(DWW), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data),
        .cfg_last(cfg_last), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
        .start(start), .abort(abort),
        .host_req(host_req), .host_word(host_word), .host_ack(host_ack),
        .dds_control_data(dds_control_data),
        .dds_control_update(dds_control_update),
        .spi_ready(spi_ready),
        .busy(busy), .done(done), .step_idx(step_idx), .skip_cnt(skip_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // dds_control stand-in: ignores a repeated word, else drops spi_ready
    // after 1-3 cycles and holds it low for 2-8 cycles.
    logic [15:0] r_last = '0;
    bit          r_arm  = 1'b0;
    int          r_del  = 0;
    int          r_len  = 0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spi_ready <= 1'b1;
            r_arm     <= 1'b0;
            r_del     <= 0;
            r_len     <= 0;
            r_last    <= '0;
        end else if (dds_control_update && dds_control_data != r_last) begin
            r_arm  <= 1'b1;
            r_del  <= int'($urandom_range(1, 3));
            r_len  <= int'($urandom_range(2, 8));
            r_last <= dds_control_data;
        end else if (r_arm) begin
            if (r_del > 1) r_del <= r_del - 1;
            else if (r_del == 1) begin
                r_del     <= 0;
                spi_ready <= 1'b0;
            end else if (r_len > 1) r_len <= r_len - 1;
            else begin
                spi_ready <= 1'b1;
                r_arm     <= 1'b0;
            end
        end
    end

    // Reference model: a sweep is an ordered walk over table indices; each
    // word is a transfer that ends on ready rise or on the ack timeout,
    // followed by a dwell during which the host may slip in a word.
    logic [15:0] m_tbl [16];
    bit          m_busy, m_sweep, m_host, m_pend;
    bit          m_fetch, m_iss, m_xfer, m_fell;
    int          m_wn, m_dw, m_idx, m_last, m_dwell, m_skip;
    bit          m_loop;
    logic [15:0] e_data;
    bit          e_upd, e_ack, e_done;

    task automatic m_go_idle();
        m_busy  = 0; m_sweep = 0; m_pend = 0;
        m_fetch = 0; m_iss   = 0; m_xfer = 0; m_dw = 0;
    endtask

    task automatic m_issue(input logic [15:0] w, input bit h);
        e_data = w; e_upd = 1; m_host = h; m_iss = 1; m_busy = 1;
    endtask

    task automatic m_finish_word();
        m_xfer = 0;
        if (m_host) e_ack = 1;
        if (m_pend || (m_host && !m_sweep)) m_go_idle();
        else m_dw = (m_dwell == 0) ? 1 : m_dwell;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = '0;
        m_go_idle();
        m_host = 0; m_idx = 0; m_skip = 0; m_last = 0; m_dwell = 0;
        m_loop = 0; m_wn = 0; m_fell = 0;
        e_data = '0; e_upd = 0; e_ack = 0; e_done = 0;
    endtask

    task automatic m_step();
        e_upd = 0; e_ack = 0; e_done = 0;
        if (!m_busy) begin
            m_pend = 0;
            if (!abort) begin
                if (host_req) begin
                    m_sweep = 0;
                    m_issue(host_word, 1);
                end else if (start) begin
                    m_last  = int'(cfg_last);
                    m_dwell = int'(cfg_dwell);
                    m_loop  = cfg_loop;
                    m_idx   = 0;
                    m_busy  = 1; m_sweep = 1; m_fetch = 1;
                end
            end
        end else if (m_fetch) begin
            m_fetch = 0;
            if (abort) m_go_idle();
            else m_issue(m_tbl[m_idx], 0);
        end else if (m_iss) begin
            m_iss = 0; m_xfer = 1; m_fell = 0; m_wn = 0;
            if (abort) m_pend = 1;
        end else if (m_xfer) begin
            if (abort) m_pend = 1;
            if (!m_fell) begin
                if (!spi_ready) m_fell = 1;
                else begin
                    m_wn++;
                    if (m_wn >= TO) begin
                        if (m_skip < 255) m_skip++;
                        m_finish_word();
                    end
                end
            end else if (spi_ready) m_finish_word();
        end else begin
            if (abort) m_go_idle();
            else if (host_req) m_issue(host_word, 1);
            else if (m_dw > 1) m_dw--;
            else if (m_idx < m_last) begin
                m_idx++; m_fetch = 1;
            end else if (m_loop) begin
                m_idx = 0; m_fetch = 1;
            end else begin
                e_done = 1;
                m_go_idle();
            end
        end
        if (tbl_wr_en) m_tbl[tbl_wr_addr] = tbl_wr_data;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            check("data", 32'(dds_control_data), 32'(e_data));
            check("update", 32'(dds_control_update), 32'(e_upd));
            check("host_ack", 32'(host_ack), 32'(e_ack));
            check("done", 32'(done), 32'(e_done));
            check("busy", 32'(busy), 32'(m_busy));
            check("step_idx", 32'(step_idx), 32'(m_idx));
            check("skip_cnt", 32'(skip_cnt), 32'(m_skip));
        end
    end

    // Event log for the directed scenarios.
    int          cyc = 0;
    logic [15:0] upd_w [$];
    int          upd_c [$];
    int          upd_i [$];
    int          gap_q [$];
    int          done_cnt  = 0;
    int          ack_cnt   = 0;
    int          last_rise = 0;
    logic        prev_rdy  = 1'b1;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rstn) prev_rdy = 1'b1;
        else begin
            if (spi_ready && !prev_rdy) last_rise = cyc;
            prev_rdy = spi_ready;
            if (dds_control_update) begin
                upd_w.push_back(dds_control_data);
                upd_c.push_back(cyc);
                upd_i.push_back(int'(step_idx));
                gap_q.push_back(cyc - last_rise);
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 0);
            end
            if (host_ack) ack_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        upd_w.delete(); upd_c.delete(); upd_i.delete(); gap_q.delete();
        done_cnt = 0; ack_cnt = 0;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        tbl_wr_en = 1; tbl_wr_addr = AW'(a); tbl_wr_data = d;
        tick();
        tbl_wr_en = 0;
    endtask

    task automatic pulse_start(output int sc);
        start = 1; sc = cyc;
        tick();
        start = 0;
    endtask

    task automatic wait_upd(input int n, input int budget);
        int k = 0;
        while (upd_w.size() < n && k < budget) begin
            tick(); k++;
        end
        check("wait_upd_timeout", 32'(upd_w.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(); k++;
        end
        check("wait_idle_timeout", 32'(busy), 0);
    endtask

    task automatic wait_rdy(input logic v, input int budget);
        int k = 0;
        while (spi_ready !== v && k < budget) begin
            tick(); k++;
        end
        check("wait_rdy_timeout", 32'(spi_ready), 32'(v));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_update"}, 32'(dds_control_update), 0);
        check({tag, "_data"}, 32'(dds_control_data), 0);
        check({tag, "_ack"}, 32'(host_ack), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_idx"}, 32'(step_idx), 0);
        check({tag, "_skip"}, 32'(skip_cnt), 0);
    endtask

    initial begin
        int sc;
        int hc;
        int n;
        int pa;

        tick(); tick();
        check_reset_vals("rst");
        rstn = 1;
        tick();

        // Basic three-word sweep.
        wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333);
        cfg_last = 2; cfg_dwell = 10; cfg_loop = 0;
        clear_logs();
        pulse_start(sc);
        wait_idle(500);
        check("basic_n", 32'(upd_w.size()), 3);
        check("basic_w0", 32'(upd_w[0]), 32'h1111);
        check("basic_w1", 32'(upd_w[1]), 32'h2222);
        check("basic_w2", 32'(upd_w[2]), 32'h3333);
        check("start_latency", 32'(upd_c[0] - sc), 2);
        check("gap1_ge11", 32'(gap_q[1] >= 11), 1);
        check("gap2_ge11", 32'(gap_q[2] >= 11), 1);
        check("basic_done", 32'(done_cnt), 1);
        check("basic_skip", 32'(skip_cnt), 0);

        // Repeated word produces one skip.
        wr(0, 16'h0A0A); wr(1, 16'h0A0A);
        cfg_last = 1; cfg_dwell = 2;
        clear_logs();
        pulse_start(sc);
        wait_idle(500);
        check("rep_n", 32'(upd_w.size()), 2);
        check("rep_skip", 32'(skip_cnt), 1);
        check("rep_model_skip", 32'(m_skip), 1);
        check("rep_done", 32'(done_cnt), 1);

        // Host word during dwell of step 1.
        wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333);
        cfg_last = 2; cfg_dwell = 10;
        clear_logs();
        pulse_start(sc);
        wait_upd(2, 300);
        wait_rdy(1'b0, 50);
        wait_rdy(1'b1, 50);
        tick(); tick(); tick();
        host_req = 1; host_word = 16'hBEEF; hc = cyc;
        pa = 0;
        while (ack_cnt == 0 && pa < 100) begin
            tick(); pa++;
        end
        host_req = 0;
        check("host_ack_seen", 32'(ack_cnt), 1);
        wait_idle(500);
        check("host_n", 32'(upd_w.size()), 4);
        check("host_w2", 32'(upd_w[2]), 32'hBEEF);
        check("host_w3", 32'(upd_w[3]), 32'h3333);
        check("host_latency", 32'(upd_c[2] - hc), 1);
        check("host_done", 32'(done_cnt), 1);

        // start and abort together in IDLE.
        clear_logs();
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        repeat (10) tick();
        check("sa_n", 32'(upd_w.size()), 0);
        check("sa_busy", 32'(busy), 0);

        // Loop, table write mid-sweep, start while busy, abort in WAIT_DONE.
        wr(0, 16'h1000); wr(1, 16'h2000); wr(2, 16'h3000); wr(3, 16'h4000);
        cfg_last = 3; cfg_dwell = 1; cfg_loop = 1;
        clear_logs();
        pulse_start(sc);
        wait_upd(1, 100);
        wr(0, 16'h5000);
        wait_upd(2, 300);
        cfg_last = 0; cfg_loop = 0;
        pulse_start(sc);
        wait_upd(5, 600);
        check("loop_i3", 32'(upd_i[3]), 3);
        check("loop_i4", 32'(upd_i[4]), 0);
        check("loop_w0", 32'(upd_w[0]), 32'h1000);
        check("loop_w4", 32'(upd_w[4]), 32'h5000);
        wait_rdy(1'b0, 50);
        tick();
        abort = 1;
        tick();
        abort = 0;
        n = upd_w.size();
        wait_idle(200);
        repeat (20) tick();
        check("abort_no_upd", 32'(upd_w.size()), 32'(n));
        check("abort_no_done", 32'(done_cnt), 0);
        check("abort_rdy_high", 32'(spi_ready), 1);

        // Reset while waiting for ack.
        wr(0, 16'h7777);
        cfg_last = 0; cfg_dwell = 0;
        clear_logs();
        pulse_start(sc);
        wait_upd(1, 100);
        tick();
        rstn = 0;
        #1;
        check_reset_vals("midrst");
        tick(); tick();
        rstn = 1;
        clear_logs();
        repeat (20) tick();
        check("post_rst_quiet", 32'(upd_w.size()), 0);

        // Random traffic against the model.
        pa = 0;
        for (int c = 0; c < 15000; c++) begin
            tick();
            start = 0; abort = 0; tbl_wr_en = 0;
            if (host_req && ack_cnt != pa) host_req = 0;
            else if (!host_req && $urandom_range(0, 149) == 0) begin
                host_req  = 1;
                host_word = 16'($urandom);
            end
            pa = ack_cnt;
            if ($urandom_range(0, 24) == 0) begin
                cfg_last  = AW'($urandom_range(0, 15));
                cfg_dwell = DWW'($urandom_range(0, 6));
                cfg_loop  = ($urandom_range(0, 3) == 0);
                start     = 1;
            end
            if ($urandom_range(0, 399) == 0) abort = 1;
            if ($urandom_range(0, 29) == 0) begin
                tbl_wr_en   = 1;
                tbl_wr_addr = AW'($urandom_range(0, 15));
                tbl_wr_data = 16'($urandom_range(0, 7));
            end
        end
        start = 0; abort = 0; tbl_wr_en = 0; host_req = 0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
